eq_mac_scheduler: RTL
=====================

# eq_mac_scheduler

Sequencer that time-shares one multiply-accumulate unit across the three equalizer bands for every audio sample. It sits between the ADC receiver's sample-done tick and the filter arithmetic: on each new sample it walks band by band and tap by tap, driving MAC clear/enable, coefficient/tap select and per-band result strobes. When all bands are finished it issues one output-valid pulse toward the gain/sum stage and the DAC sender. Bands whose gain code is 0 (muted) are skipped to save cycles.

## Interface
- BANDS, 3, number of equalizer bands processed per sample
- TAPS, 5, MAC cycles per active band (one per coefficient)
- BAND_W, 2, width of band_sel (must hold BANDS-1)
- TAP_W, 3, width of tap_idx (must hold TAPS-1)

- clk  in  1  system clock (the sclk domain of the datapath)
- rst  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle pulse: new ADC word available
- gain1, gain2, gain3  in  2 each  band gain codes; 0 = band muted
- ovr_clr  in  1  clears sticky overrun flag (only with EQ_MAC_OVR_EN)
- busy  out  1  high whenever state is not IDLE
- mac_clr  out  1  clear shared accumulator
- mac_en  out  1  accumulate product for (band_sel, tap_idx)
- band_sel  out  BAND_W  band currently processed
- tap_idx  out  TAP_W  coefficient/delay-line index for current MAC
- acc_store  out  1  latch accumulator into result register of band_sel
- out_valid  out  1  one-cycle pulse: all band results stored
- overrun  out  1  sticky: sample_valid arrived while busy

## Operation
- States: IDLE, CLR, MAC, STORE, DONE. All outputs decoded from registered state/counters (Moore).
- IDLE: on sample_valid latch gain1..3 into internal g_lat, band=0, go CLR. Otherwise stay.
- CLR: mac_clr=1, tap=0. Next: MAC if g_lat[band]!=0, else STORE (accumulator is cleared, so muted band stores 0).
- MAC: mac_en=1, tap_idx=tap; tap increments each cycle; after tap==TAPS-1 go STORE.
- STORE: acc_store=1. If band==BANDS-1 go DONE, else band+1, go CLR.
- DONE: out_valid=1, go IDLE.
- band_sel valid in CLR/MAC/STORE; band_sel and tap_idx are 0 in IDLE and DONE.
- Gains are sampled only at acceptance; gain changes during a sample take effect on the next sample.
- sample_valid when state != IDLE (including DONE): pulse dropped, current sequence unaffected; overrun set (with macro).
- Simultaneous ovr_clr and new overrun event: set wins.
- Reset (any time, mid-sequence included): state IDLE, band=0, tap=0, g_lat=0, overrun=0; all outputs 0 while rst low and in first cycle after release.

## Timing
- sample_valid sampled high at edge 0 -> CLR in cycle 1.
- Active band costs TAPS+2 cycles (CLR, TAPS×MAC, STORE); muted band costs 2 (CLR, STORE).
- Defaults, all bands active: busy cycles 1..22, out_valid in cycle 22, IDLE in cycle 23; next sample accepted from cycle 23.
- All bands muted: out_valid in cycle 7.
- mac_en high exactly TAPS consecutive cycles per active band, tap_idx 0..TAPS-1 in order; no wrap beyond TAPS-1.
- Exactly BANDS acc_store pulses and one out_valid per accepted sample.

## Configuration
- EQ_MAC_OVR_EN defined: overrun register implemented; set on dropped sample_valid, cleared by ovr_clr or reset.
- Not defined: overrun tied 0, ovr_clr ignored; dropped pulses still silently discarded.

## Test plan
- Reset then single sample_valid, gains 1/2/3 -> mac_clr at cycles 1,8,15; mac_en cycles 2-6, 9-13, 16-20 with tap_idx 0..4; acc_store at 7,14,21 with band_sel 0,1,2; out_valid at 22.
- Gains 0/2/0 -> band 0: CLR 1, STORE 2; band 1: CLR 3, MAC 4-8, STORE 9; band 2: CLR 10, STORE 11; out_valid at 12.
- sample_valid again at cycle 10 (busy) -> ignored, sequence unchanged, overrun=1 (macro) / 0 (no macro); ovr_clr pulse -> overrun 0.
- Gains changed from 3/3/3 to 0/0/0 at cycle 5 -> current sample still runs all three bands; next sample takes 7-cycle muted path.
- rst low at cycle 12 -> all outputs 0 immediately; after release, sample_valid restarts from band 0, tap 0.
- Back-to-back samples, second pulse in cycle 23 -> accepted, CLR in cycle 24, no overrun.

Source files
------------

// File: rtl/eq_mac_scheduler.sv
// Sequencer time-sharing one MAC across the equalizer bands for each audio sample.
// Optional sticky overrun flag is built only when EQ_MAC_OVR_EN is defined.
module eq_mac_scheduler #(
    parameter int BANDS  = 3,
    parameter int TAPS   = 5,
    parameter int BAND_W = 2,
    parameter int TAP_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [1:0]        gain1,
    input  logic [1:0]        gain2,
    input  logic [1:0]        gain3,
    input  logic              ovr_clr,
    output logic              busy,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [BAND_W-1:0] band_sel,
    output logic [TAP_W-1:0]  tap_idx,
    output logic              acc_store,
    output logic              out_valid,
    output logic              overrun,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        MAC   = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(BANDS - 1);
    localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(TAPS - 1);

    state_t                 state_q;
    logic [BAND_W-1:0]      band_q;
    logic [TAP_W-1:0]       tap_q;
    logic [BANDS-1:0][1:0]  g_lat_q;
    logic                   band_active;

    assign band_active = (g_lat_q[band_q] != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            band_q  <= '0;
            tap_q   <= '0;
            g_lat_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Gains are frozen here so mid-sample changes wait for the next sample.
                    if (sample_valid) begin
                        g_lat_q <= {gain3, gain2, gain1};
                        band_q  <= '0;
                        tap_q   <= '0;
                        state_q <= CLR;
                    end
                end
                CLR: begin
                    tap_q   <= '0;
                    state_q <= band_active ? MAC : STORE;
                end
                MAC: begin
                    if (tap_q == LAST_TAP) begin
                        tap_q   <= '0;
                        state_q <= STORE;
                    end else begin
                        tap_q <= tap_q + TAP_W'(1);
                    end
                end
                STORE: begin
                    if (band_q == LAST_BAND) begin
                        state_q <= DONE;
                    end else begin
                        band_q  <= band_q + BAND_W'(1);
                        state_q <= CLR;
                    end
                end
                DONE: begin
                    band_q  <= '0;
                    tap_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        mac_clr   = (state_q == CLR);
        mac_en    = (state_q == MAC);
        acc_store = (state_q == STORE);
        out_valid = (state_q == DONE);
        band_sel  = '0;
        tap_idx   = '0;
        if (state_q == CLR || state_q == MAC || state_q == STORE) begin
            band_sel = band_q;
        end
        if (state_q == MAC) begin
            tap_idx = tap_q;
        end
        state_o = state_q;
    end

`ifdef EQ_MAC_OVR_EN
    logic overrun_q;
    logic overrun_d;

    // A new pulse landing on a busy sequencer wins over a same-cycle clear.
    always_comb begin
        overrun_d = overrun_q;
        if (sample_valid && state_q != IDLE) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr = ovr_clr;
    assign overrun        = 1'b0;
`endif

endmodule
